// File: rtl/boot_loader.sv
// boot_loader: bus initiator that copies a program image from external storage into SRAM
// and holds the core until the copy ends. Define BOOT_LOADER_VERIFY_EN to add read-back verify.
module boot_loader #(
  parameter int unsigned MEM_W     = 32,
  parameter logic [31:0] SRC_BASE  = 32'h0000_2000,
  parameter logic [31:0] DST_BASE  = 32'h0000_1000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [10:0]        word_count,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [10:0]        words_done,
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  output logic               mem_we_o,
  output logic [MEM_W/8-1:0] mem_be_o,
  output logic [MEM_W-1:0]   mem_wdata_o,
  input  logic               mem_rvalid_i,
  input  logic               mem_err_i,
  input  logic [MEM_W-1:0]   mem_rdata_i
);

  localparam int unsigned     BE_W     = MEM_W / 8;
  localparam int unsigned     TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [10:0]     MAX_N    = 11'(MAX_WORDS);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_BUS  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
`ifdef BOOT_LOADER_VERIFY_EN
  localparam logic [1:0] ERR_VFY  = 2'd3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
`ifdef BOOT_LOADER_VERIFY_EN
    ST_VERIFY = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [10:0] i);
    return base + {19'd0, i, 2'b00};
  endfunction

  state_e            state_q, state_d;
  logic [10:0]       n_q, n_d;
  logic [10:0]       idx_q, idx_d;
  logic [10:0]       wd_q, wd_d;
  logic [MEM_W-1:0]  data_q, data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              busy_q, busy_d;
  logic              hold_q, hold_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [MEM_W-1:0]  wdata_q, wdata_d;

  logic [10:0]       idx_inc;
  logic              last_word;
  logic [10:0]       n_start;

  // Next-state, status and bus-output decode; outputs are derived from next-state values
  // so that every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    code_d  = code_q;
    tmo_d   = tmo_q;

    idx_inc   = idx_q + 11'd1;
    last_word = (idx_inc == n_q);
    n_start   = (word_count > MAX_N) ? MAX_N : word_count;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          n_d     = n_start;
          idx_d   = 11'd0;
          wd_d    = 11'd0;
          error_d = 1'b0;
          code_d  = ERR_NONE;
          tmo_d   = {TMO_W{1'b0}};
          if (n_start == 11'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_READ;
            done_d  = 1'b0;
          end
        end else begin
          tmo_d = {TMO_W{1'b0}};
        end
      end

      ST_READ: begin
        if (mem_err_i) begin
          state_d = ST_FAIL;
          error_d = 1'b1;
          code_d  = ERR_BUS;
        end else if (mem_rvalid_i) begin
          data_d  = mem_rdata_i;
          state_d = ST_WRITE;
          tmo_d   = {TMO_W{1'b0}};
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAIL;
          error_d = 1'b1;
          code_d  = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_WRITE: begin
        if (mem_err_i) begin
          state_d = ST_FAIL;
          error_d = 1'b1;
          code_d  = ERR_BUS;
        end else if (mem_rvalid_i) begin
          tmo_d = {TMO_W{1'b0}};
`ifdef BOOT_LOADER_VERIFY_EN
          state_d = ST_VERIFY;
`else
          idx_d   = idx_inc;
          wd_d    = wd_q + 11'd1;
          state_d = last_word ? ST_DONE : ST_READ;
          done_d  = last_word;
`endif
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAIL;
          error_d = 1'b1;
          code_d  = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

`ifdef BOOT_LOADER_VERIFY_EN
      ST_VERIFY: begin
        if (mem_err_i) begin
          state_d = ST_FAIL;
          error_d = 1'b1;
          code_d  = ERR_BUS;
        end else if (mem_rvalid_i) begin
          tmo_d = {TMO_W{1'b0}};
          if (mem_rdata_i == data_q) begin
            idx_d   = idx_inc;
            wd_d    = wd_q + 11'd1;
            state_d = last_word ? ST_DONE : ST_READ;
            done_d  = last_word;
          end else begin
            state_d = ST_FAIL;
            error_d = 1'b1;
            code_d  = ERR_VFY;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FAIL;
          error_d = 1'b1;
          code_d  = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        tmo_d   = {TMO_W{1'b0}};
      end
    endcase

    busy_d = (state_d == ST_READ) || (state_d == ST_WRITE)
`ifdef BOOT_LOADER_VERIFY_EN
             || (state_d == ST_VERIFY)
`endif
             ;
    hold_d  = (state_d != ST_DONE);
    req_d   = busy_d;
    we_d    = (state_d == ST_WRITE);
    be_d    = req_d ? {BE_W{1'b1}} : {BE_W{1'b0}};
    wdata_d = (state_d == ST_WRITE) ? data_d : {MEM_W{1'b0}};

    case (state_d)
      ST_READ:   addr_d = word_addr(SRC_BASE, idx_d);
      ST_WRITE:  addr_d = word_addr(DST_BASE, idx_d);
`ifdef BOOT_LOADER_VERIFY_EN
      ST_VERIFY: addr_d = word_addr(DST_BASE, idx_d);
`endif
      default:   addr_d = 32'h0000_0000;
    endcase
  end

  // State, status and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      n_q     <= 11'd0;
      idx_q   <= 11'd0;
      wd_q    <= 11'd0;
      data_q  <= {MEM_W{1'b0}};
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
      tmo_q   <= {TMO_W{1'b0}};
      busy_q  <= 1'b0;
      hold_q  <= 1'b1;
      req_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      we_q    <= 1'b0;
      be_q    <= {BE_W{1'b0}};
      wdata_q <= {MEM_W{1'b0}};
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign core_hold   = hold_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = code_q;
  assign words_done  = wd_q;
  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: doc/boot_loader.md
# boot_loader

Bus-initiator block that copies a program image from external storage into SRAM scratch memory over the core memory-request interface before the core is released. It sits beside the core as a second initiator into the memory-mapped responder and drives the same req/addr/we/be/wdata → rvalid/err/rdata protocol that the core uses. It holds the core stalled until the copy finishes and reports completion or failure status.

## Interface
- MEM_W, 32, data bus width in bits; must be 32.
- SRC_BASE, 32'h0000_2000, first source byte address (external storage).
- DST_BASE, 32'h0000_1000, first destination byte address (SRAM scratch).
- MAX_WORDS, 1024, copy length limit in words (4 KiB SRAM).
- TIMEOUT, 255, number of cycles to wait for a response before failing.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that begins a copy; sampled only in IDLE, DONE and FAIL.
- word_count  in  11  number of words to copy; sampled on start.
- core_hold  out  1  keeps the core stalled while high.
- busy  out  1  high while a copy is in progress.
- done  out  1  copy completed successfully; sticky until the next start.
- error  out  1  copy failed; sticky until the next start.
- err_code  out  2  failure reason: 0 = none, 1 = bus err, 2 = timeout, 3 = verify mismatch.
- words_done  out  11  number of words fully written.
- mem_req_o  out  1  request to the responder.
- mem_addr_o  out  32  byte address of the request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_be_o  out  MEM_W/8  byte enables; always 4'hF while req is high, 0 otherwise.
- mem_wdata_o  out  MEM_W  write data.
- mem_rvalid_i  in  1  response from the responder; read data is valid with it.
- mem_err_i  in  1  error response from the responder.
- mem_rdata_i  in  MEM_W  read data.

## Operation
- States: IDLE, READ, WRITE, VERIFY (present only with the macro), DONE, FAIL.
- IDLE → READ on start.
  - Latches n = min(word_count, MAX_WORDS).
  - Clears idx, words_done, done, error and err_code.
  - If n == 0, goes directly to DONE with no bus traffic.
- READ:
  - Drives req=1, we=0, addr = SRC_BASE + 4·idx.
  - On rvalid, latches rdata into the data register and goes to WRITE.
- WRITE:
  - Drives req=1, we=1, addr = DST_BASE + 4·idx, wdata = data register.
  - On rvalid, goes to VERIFY (macro defined); otherwise increments idx and words_done.
  - After the increment: DONE if idx == n, else READ.
- Address arithmetic is 32-bit modulo 2^32; wrap-around is not checked.
- Any waiting state:
  - mem_err_i → FAIL with err_code 1. err wins if it arrives in the same cycle as rvalid.
  - TIMEOUT cycles without a response → FAIL with err_code 2. The timeout counter clears on every state entry.
- req stays high through the whole wait. A response is accepted in any cycle req is high, including the first.
- rvalid or err arriving while req is low is ignored.
- DONE: done=1, core_hold=0, busy=0.
- FAIL: error=1, core_hold=1, busy=0.
- start in DONE or FAIL restarts the copy exactly as from IDLE. start while busy is ignored.
- busy = (state ∈ {READ, WRITE, VERIFY}).
- core_hold = 0 only in DONE.

## Timing
- State and all status/data registers update on posedge clk. Bus outputs are decoded from the registered state and registers.
- Reset values:
  - state IDLE.
  - req=0, addr=0, we=0, be=0, wdata=0.
  - busy=0, done=0, error=0, err_code=0, words_done=0.
  - core_hold=1.
- Reset asserted mid-copy aborts within that same edge: req=0 in the next cycle, no further writes, core_hold=1.
- start sampled at edge t → req high from cycle t+1.
- A response in cycle k (k ≥ 0) of a phase causes req to drop or change phase at the next edge.
- Each phase takes k+1 cycles.
- Words are strictly sequential; one request is outstanding at a time.
- Last write (or verify) response at edge t → done=1 and core_hold=0 in cycle t+1.
- Timeout: with no response, FAIL is entered at the edge ending the TIMEOUT-th cycle of req-high.

## Configuration
- BOOT_LOADER_VERIFY_EN defined:
  - After each WRITE response, enters VERIFY: req=1, we=0, addr = DST_BASE + 4·idx.
  - On rvalid, compares rdata with the data register.
    - Equal → increments idx and words_done, then DONE or READ as above.
    - Unequal → FAIL with err_code 3.
  - err and timeout in VERIFY behave as in the other waiting states.
- Not defined: VERIFY state and comparator are absent, WRITE proceeds directly, and err_code 3 is never produced.

## Test plan
- Copy with a responder model at 2-cycle latency: word_count=4, source words 0xA0..0xA3 → writes to 0x1000/0x1004/0x1008/0x100C with matching data; done=1 and words_done=4, 6 cycles per word without verify.
- word_count=0 → done=1 one cycle after start, req never asserted, core_hold=0.
- Bus error: responder asserts err on the read of word 2 → FAIL with err_code=1, words_done=2, core_hold=1; no write to 0x1008.
- Timeout with TIMEOUT=8: responder silent on a write → FAIL with err_code=2 exactly 8 req-high cycles after that write begins.
- Edge cases:
  - word_count=2000 → exactly 1024 words copied, last write at address 0x1FFC.
  - start pulsed mid-copy is ignored.
  - rvalid and err in the same cycle → err_code=1.
- With the macro defined:
  - Responder corrupts the readback of word 1 → err_code=3, words_done=1.
  - rst low mid-copy → all outputs return to their reset values in the next cycle.
